// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM states,
// reset cause encoding and reset scope.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    HOLD,
    REL_MEM,
    REL_PERIPH,
    REL_CPU,
    START
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR    = 2'd0,
    CAUSE_GLOBAL = 2'd1,
    CAUSE_WDG    = 2'd2,
    CAUSE_SOFT   = 2'd3
  } cause_t;

  typedef enum logic {
    SCOPE_GLOBAL = 1'b0,
    SCOPE_CPU    = 1'b1
  } scope_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously,
// deasserts synchronously to i_clock.
module reset_sync (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_reset
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= 1'b0;
      r_sync <= r_meta;
    end
  end

  assign o_reset = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: halt handshake, per-domain reset
// assertion and ordered release memory -> peripherals -> CPU.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_DELAY  = 8,
  parameter int HALT_TIMEOUT = 1024
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_req_soft,
  input  logic       i_req_global,
  input  logic       i_req_wdg,
  input  logic       i_halt_ack,
  output logic       o_halt_req,
  output logic       o_reset_mem,
  output logic       o_reset_periph,
  output logic       o_reset_cpu,
  output logic       o_start,
  output logic       o_busy,
  output logic [1:0] o_cause
);

  localparam int CW =
    $clog2(max3(HOLD_CYCLES, STAGE_DELAY, HALT_TIMEOUT)) + 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] HALT_LAST  = CW'(HALT_TIMEOUT - 1);

  logic          w_rst;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  scope_t        r_scope, w_scope_nxt;
  cause_t        r_cause, w_cause_nxt;
  logic          w_hard;
  cause_t        w_hard_cause;

  logic w_halt_nxt, w_mem_nxt, w_periph_nxt;
  logic w_cpu_nxt, w_start_nxt, w_busy_nxt;

  reset_sync u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_reset (w_rst)
  );

  assign w_hard = i_req_global | i_req_wdg;
  assign w_hard_cause = i_req_global ? CAUSE_GLOBAL : CAUSE_WDG;

  always_ff @(posedge i_clock or posedge w_rst) begin
    if (w_rst) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_scope <= SCOPE_GLOBAL;
      r_cause <= CAUSE_POR;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_scope <= w_scope_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scope_nxt = r_scope;
    w_cause_nxt = r_cause;
    w_cnt_nxt   = r_cnt + 1'b1;
    if (r_state == IDLE) begin
      w_cnt_nxt = '0;
      if (w_hard) begin
        w_state_nxt = HALT;
        w_scope_nxt = SCOPE_GLOBAL;
        w_cause_nxt = w_hard_cause;
      end else if (i_req_soft) begin
        w_state_nxt = HALT;
        w_scope_nxt = SCOPE_CPU;
        w_cause_nxt = CAUSE_SOFT;
      end
    end else if (w_hard) begin
      // CPU is already halted or in reset: skip the handshake
      w_state_nxt = HOLD;
      w_scope_nxt = SCOPE_GLOBAL;
      w_cause_nxt = w_hard_cause;
    end else begin
      unique case (r_state)
        HALT:
          if (i_halt_ack || r_cnt == HALT_LAST)
            w_state_nxt = HOLD;
        HOLD:
          if (r_cnt == HOLD_LAST) begin
            if (r_scope == SCOPE_GLOBAL) w_state_nxt = REL_MEM;
            else w_state_nxt = REL_CPU;
          end
        REL_MEM:
          if (r_cnt == STAGE_LAST) w_state_nxt = REL_PERIPH;
        REL_PERIPH:
          if (r_cnt == STAGE_LAST) w_state_nxt = REL_CPU;
        REL_CPU:
          if (r_cnt == STAGE_LAST) w_state_nxt = START;
        default:
          w_state_nxt = IDLE;
      endcase
    end
    if (w_state_nxt != r_state || (r_state != IDLE && w_hard))
      w_cnt_nxt = '0;
  end

  always_comb begin
    w_halt_nxt   = 1'b0;
    w_mem_nxt    = 1'b0;
    w_periph_nxt = 1'b0;
    w_cpu_nxt    = 1'b0;
    w_start_nxt  = 1'b0;
    w_busy_nxt   = (w_state_nxt != IDLE);
    unique case (w_state_nxt)
      HALT: w_halt_nxt = 1'b1;
      HOLD: begin
        w_mem_nxt    = (w_scope_nxt == SCOPE_GLOBAL);
        w_periph_nxt = (w_scope_nxt == SCOPE_GLOBAL);
        w_cpu_nxt    = 1'b1;
      end
      REL_MEM: begin
        w_periph_nxt = 1'b1;
        w_cpu_nxt    = 1'b1;
      end
      REL_PERIPH: w_cpu_nxt = 1'b1;
      START: w_start_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clock or posedge w_rst) begin
    if (w_rst) begin
      o_halt_req     <= 1'b0;
      o_reset_mem    <= 1'b1;
      o_reset_periph <= 1'b1;
      o_reset_cpu    <= 1'b1;
      o_start        <= 1'b0;
      o_busy         <= 1'b1;
      o_cause        <= CAUSE_POR;
    end else begin
      o_halt_req     <= w_halt_nxt;
      o_reset_mem    <= w_mem_nxt;
      o_reset_periph <= w_periph_nxt;
      o_reset_cpu    <= w_cpu_nxt;
      o_start        <= w_start_nxt;
      o_busy         <= w_busy_nxt;
      o_cause        <= w_cause_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against a timeline
// model: expected outputs derived from time since reset assertion.
module tb_reset_sequencer;

  localparam int H  = 16;
  localparam int S  = 8;
  localparam int HT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_soft = 1'b0;
  logic       req_global = 1'b0;
  logic       req_wdg = 1'b0;
  logic       halt_ack = 1'b0;
  logic       halt_req;
  logic       rst_mem, rst_periph, rst_cpu;
  logic       start, busy;
  logic [1:0] cause;

  int total = 0;
  int bad = 0;
  int starts = 0;

  // model: mode 0 idle, 1 halt handshake, 2 reset timeline
  int m_mode = 2;
  int m_k = 0;
  int m_glob = 1;
  int m_cause = 0;
  int m_sync = 2;
  int ackd = 0;
  bit rand_mode = 0;

  reset_sequencer #(
    .HOLD_CYCLES  (H),
    .STAGE_DELAY  (S),
    .HALT_TIMEOUT (HT)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_req_soft     (req_soft),
    .i_req_global   (req_global),
    .i_req_wdg      (req_wdg),
    .i_halt_ack     (halt_ack),
    .o_halt_req     (halt_req),
    .o_reset_mem    (rst_mem),
    .o_reset_periph (rst_periph),
    .o_reset_cpu    (rst_cpu),
    .o_start        (start),
    .o_busy         (busy),
    .o_cause        (cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int seq_end();
    return H + (m_glob != 0 ? 3 * S : S);
  endfunction

  task automatic check_all();
    bit sq;
    sq = (m_mode == 2);
    chk("halt", halt_req, m_mode == 1);
    chk("busy", busy, m_mode != 0);
    chk("mem", rst_mem, sq && m_glob != 0 && m_k < H);
    chk("periph", rst_periph, sq && m_glob != 0 && m_k < H + S);
    chk("cpu", rst_cpu,
        sq && m_k < H + (m_glob != 0 ? 2 * S : 0));
    chk("start", start, sq && m_k == seq_end());
    chk("cause", cause, m_cause);
  endtask

  task automatic model_reset();
    m_mode = 2;
    m_k = 0;
    m_glob = 1;
    m_cause = 0;
    m_sync = 2;
  endtask

  task automatic model_update();
    int old_mode;
    old_mode = m_mode;
    if (rst) model_reset();
    else if (m_sync > 0) m_sync--;
    else if (m_mode == 0) begin
      if (req_global || req_wdg) begin
        m_mode = 1; m_k = 0; m_glob = 1;
        m_cause = req_global ? 1 : 2;
      end else if (req_soft) begin
        m_mode = 1; m_k = 0; m_glob = 0; m_cause = 3;
      end
    end else if (req_global || req_wdg) begin
      m_mode = 2; m_k = 0; m_glob = 1;
      m_cause = req_global ? 1 : 2;
    end else if (m_mode == 1) begin
      if (halt_ack || m_k == HT - 1) begin
        m_mode = 2; m_k = 0;
      end else m_k++;
    end else begin
      if (m_k == seq_end()) m_mode = 0;
      else m_k++;
    end
    if (rand_mode && m_mode == 1 && old_mode != 1)
      ackd = ($urandom % 8 == 0) ? 2000 : $urandom_range(0, 6);
  endtask

  task automatic step();
    if (m_mode == 1) halt_ack = (m_k >= ackd);
    else halt_ack = rand_mode ? 1'($urandom % 2) : 1'b0;
    model_update();
    @(negedge clk);
    check_all();
    if (start) starts++;
    req_soft = 0;
    req_global = 0;
    req_wdg = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset(input int hold);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_mem", rst_mem, 1);
    chk("ar_periph", rst_periph, 1);
    chk("ar_cpu", rst_cpu, 1);
    chk("ar_busy", busy, 1);
    chk("ar_halt", halt_req, 0);
    chk("ar_cause", cause, 0);
    model_reset();
    @(negedge clk);
    run(hold);
    rst = 1'b0;
  endtask

  task automatic wait_seq_k(input int k);
    int i;
    i = 0;
    while (!(m_mode == 2 && m_k == k) && i < 2000) begin
      step();
      i++;
    end
    chk("reach_k", (m_mode == 2 && m_k == k), 1);
  endtask

  initial begin
    async_reset(3);
    run(60);
    chk("por_idle", busy, 0);

    ackd = 2;
    req_soft = 1;
    run(40);
    chk("soft_cause", cause, 3);

    ackd = 5000;
    req_global = 1;
    run(1100);

    ackd = 0;
    req_global = 1;
    req_wdg = 1;
    req_soft = 1;
    run(60);
    chk("multi_cause", cause, 1);

    ackd = 0;
    req_global = 1;
    step();
    wait_seq_k(H + S + 2);
    starts = 0;
    req_wdg = 1;
    step();
    chk("wdg_mem", rst_mem, 1);
    run(90);
    chk("wdg_starts", starts, 1);
    chk("wdg_cause", cause, 2);

    req_global = 1;
    step();
    wait_seq_k(5);
    req_soft = 1;
    step();
    wait_seq_k(H + 2);
    chk("soft_ign_cause", cause, 1);
    async_reset(2);
    run(60);

    rand_mode = 1;
    for (int i = 0; i < 15000; i++) begin
      req_global = ($urandom % 200 == 0);
      req_wdg = ($urandom % 250 == 0);
      req_soft = ($urandom % 150 == 0);
      if ($urandom % 4000 == 0) async_reset($urandom_range(1, 3));
      else step();
    end
    rand_mode = 0;
    run(1200);
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller that turns reset requests into ordered, per-domain reset outputs.
- Request sources are pulse-level requests from the debounced reset switch logic, the watchdog and a software register.
- Before any reset, it asks the CPU bus master to quiesce through a halt request/acknowledge handshake.
- It then asserts the domain resets, releases them in the order memory -> peripherals -> CPU, and issues a one-cycle start pulse.

Parameters:
- HOLD_CYCLES, 16, cycles all selected domain resets stay asserted before release begins (>=1).
- STAGE_DELAY, 8, cycles between successive domain releases (>=1).
- HALT_TIMEOUT, 1024, maximum cycles to wait for i_halt_ack before forcing reset (>=1).

Ports:
- i_clock  input  1  system clock.
- i_reset  input  1  asynchronous, active-high reset (power-on).
- i_req_soft  input  1  single-cycle pulse; request CPU-only reset.
- i_req_global  input  1  single-cycle pulse; request full reset of all domains.
- i_req_wdg  input  1  single-cycle pulse; watchdog expiry, treated as a global reset.
- i_halt_ack  input  1  CPU has quiesced the bus; level.
- o_halt_req  output  1  request CPU to quiesce; level.
- o_reset_mem  output  1  memory-controller domain reset, active high.
- o_reset_periph  output  1  peripheral domain reset, active high.
- o_reset_cpu  output  1  CPU domain reset, active high.
- o_start  output  1  one-cycle pulse after the CPU is released.
- o_busy  output  1  high whenever state != IDLE.
- o_cause  output  2  last reset cause: 0 power-on, 1 global, 2 watchdog, 3 soft.

Behaviour:
- Asynchronous reset (i_reset=1):
  - state=HOLD, cause=0, scope=global, counter=0.
  - o_reset_mem/periph/cpu=1, o_halt_req=0, o_start=0, o_busy=1.
- Deassertion of i_reset is synchronized internally with a 2-flop synchronizer before it affects the FSM.
- States: IDLE, HALT, HOLD, REL_MEM, REL_PERIPH, REL_CPU, START.
- IDLE:
  - All resets 0.
  - Request priority per cycle: global > wdg > soft.
  - Any accepted request sets cause, sets scope (global for global/wdg, cpu for soft), sets o_halt_req=1 next cycle, counter=0, -> HALT.
- HALT:
  - Advance to HOLD when i_halt_ack=1, or when counter reaches HALT_TIMEOUT-1.
  - On entry to HOLD: o_halt_req=0, counter=0.
  - Assert resets per scope: global -> mem, periph and cpu =1; cpu scope -> only cpu=1.
- HOLD:
  - Count HOLD_CYCLES cycles, then -> REL_MEM with counter=0.
  - With cpu scope, skip directly to REL_CPU.
- REL_MEM:
  - o_reset_mem=0 on entry.
  - After STAGE_DELAY cycles -> REL_PERIPH.
- REL_PERIPH:
  - o_reset_periph=0 on entry.
  - After STAGE_DELAY cycles -> REL_CPU.
- REL_CPU:
  - o_reset_cpu=0 on entry.
  - After STAGE_DELAY cycles -> START.
- START: o_start=1 for exactly one cycle, -> IDLE.
- Latency:
  - Global request with immediate ack, request cycle = 0: reset asserted at cycle 2, o_reset_mem falls at 2+HOLD_CYCLES, periph +STAGE_DELAY, cpu +STAGE_DELAY, o_start STAGE_DELAY cycles after cpu release.
  - Soft request: cpu released at 2+HOLD_CYCLES, o_start STAGE_DELAY later.
- Requests while busy:
  - Global/wdg request in any state other than IDLE restarts at HOLD with scope=global and updated cause. No halt phase is repeated, since the CPU is already halted or in reset.
  - Soft request while busy is dropped; cause is unchanged.
  - Simultaneous requests are resolved by the priority above.
- Counter:
  - Width $clog2(max(HOLD_CYCLES, STAGE_DELAY, HALT_TIMEOUT))+1, unsigned.
  - Cleared on every state transition.
  - Never wraps, because every state exits at its terminal count.
- i_halt_ack is ignored outside HALT.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-sequence (i_reset=1) returns immediately to the async reset values above.

Decomposition:
- Package reset_sequencer_pkg:
  - state_t enum (IDLE, HALT, HOLD, REL_MEM, REL_PERIPH, REL_CPU, START).
  - cause_t enum (CAUSE_POR=0, CAUSE_GLOBAL=1, CAUSE_WDG=2, CAUSE_SOFT=3).
  - scope_t enum (SCOPE_GLOBAL, SCOPE_CPU).
- One sub-module, reset_sync: 2-flop synchronizer producing the deasserted-synchronous internal reset from i_reset.

Test Plan:
- Power-on, defaults (16/8/1024): release i_reset -> all resets high; mem falls ~18 cycles later (+2 sync); periph 8 cycles after mem; cpu 8 cycles after periph; o_start 1 cycle high 8 cycles after cpu; o_cause=0; o_busy low after START.
- Soft request, ack returned 3 cycles after o_halt_req -> o_halt_req high 3 cycles; only o_reset_cpu asserted for 16 cycles; mem/periph stay 0; o_start 8 cycles after release; o_cause=3.
- Global request, i_halt_ack held 0 -> o_halt_req high exactly 1024 cycles, then full sequence; o_cause=1.
- Same-cycle pulses on i_req_global, i_req_wdg, i_req_soft -> single global-scope sequence; o_cause=1.
- i_req_wdg during REL_PERIPH (mem already released) -> all three resets reasserted next cycle; HOLD restarts 16 cycles; o_cause=2; exactly one o_start at the end.
- Soft request during HOLD of a global sequence -> ignored, sequence timing unchanged, o_cause stays 1; then i_reset asserted during REL_MEM -> all resets high immediately (asynchronously), o_cause=0.
